demux_dispatch_ctrl: RTL and testbench
======================================

DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, the data word width.
REQ-002 SHALL have parameter TIMEOUT, default 15, the stall cycles allowed before retargeting (range 1..15).
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk rises, rst_n resets when low; all registers reset asynchronously and are released synchronously to clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  source word available.
REQ-007 in_data  input  DW  source word.
REQ-008 in_ready  output  1  controller accepts a word this cycle.
REQ-009 dest_en  input  4  per-destination enable mask.
REQ-010 dest_ready  input  4  per-destination accept strobe.
REQ-011 sel  output  2  demux select (index of current destination).
REQ-012 out_valid  output  4  one-hot valid, bit sel only.
REQ-013 out_data  output  DW  held word, common to all destinations.
REQ-014 busy  output  1  high in state HOLD.
REQ-015 retarget_cnt  output  8  count of timeout retargets.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-017 In IDLE, in_ready SHALL equal |dest_en; out_valid SHALL be 4'b0000.
REQ-018 In IDLE, when in_valid and in_ready are both high, the block SHALL capture in_data into the hold register, load sel with the first enabled index after last-served pointer ptr (order ptr+1, ptr+2, ptr+3, ptr, modulo 4), clear the stall counter, and enter HOLD on the next edge.
REQ-019 In HOLD, in_ready SHALL be 0, out_valid SHALL be one-hot at bit sel, and out_data SHALL be the held word, stable until completion.
REQ-020 In HOLD, when dest_ready[sel] is high, the transfer SHALL complete: ptr<=sel, return to IDLE; the next acceptance is possible no earlier than the following cycle (one word per 2 cycles minimum).
REQ-021 dest_ready bits other than sel SHALL be ignored.
REQ-022 In HOLD without dest_ready[sel], the 4-bit stall counter SHALL increment each cycle.
REQ-023 When the stall counter reaches TIMEOUT, or dest_en[sel] is low, the block SHALL retarget: sel<=next enabled index after sel, excluding sel; stall counter<=0; retarget_cnt increments, saturating at 255.
REQ-024 On retarget, if no other destination is enabled but dest_en[sel] is high, sel SHALL remain unchanged, the counter SHALL clear, and retarget_cnt SHALL still increment.
REQ-025 If dest_en becomes 4'b0000 in HOLD, the word SHALL be dropped: return to IDLE, ptr unchanged, retarget_cnt unchanged.
REQ-026 Completion takes priority over retarget when dest_ready[sel] and the timeout coincide.
REQ-027 Changes to dest_en SHALL affect selection only at acceptance or retarget, never mid-cycle glitching of sel.
REQ-028 All outputs SHALL be registered or derived from state/sel only, with no combinational path from in_valid to out_valid.

Reset
REQ-029 On rst_n low: state=IDLE, sel=2'b00, ptr=2'b11 (first grant goes to index 0), hold register=0, stall counter=0, retarget_cnt=0, out_valid=0, busy=0.
REQ-030 Reset asserted in HOLD SHALL abort the transfer immediately (asynchronous); the word is lost.

Verification
REQ-031 dest_en=1111, dest_ready=1111, in_valid held, in_data=A1,A2,A3,A4,A5 -> sel sequence 0,1,2,3,0; each out_valid one cycle; one word every 2 cycles.
REQ-032 dest_en=0101, four words -> sel 0,2,0,2; out_valid never 0010 or 1000.
REQ-033 dest_en=1111, dest_ready=0000, one word 5A -> out_valid=0001 for 15 cycles, then sel=1, retarget_cnt=1; then dest_ready=0010 -> completes, IDLE, out_data 5A seen at destination 1.
REQ-034 In HOLD sel=2, drop dest_en to 0000 -> next cycle IDLE, in_ready=0, retarget_cnt unchanged; restore dest_en=1000 -> next word goes to sel=3.
REQ-035 dest_ready[sel] asserted exactly on the TIMEOUT cycle -> completion, no retarget, retarget_cnt unchanged.
REQ-036 rst_n pulsed low in HOLD -> out_valid=0, busy=0, sel=0 asynchronously; after release, first word goes to index 0.

Source files
------------

// File: rtl/demux_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// demux_dispatch_ctrl
//
// Purpose: accepts one source word at a time, holds it, and offers it to one of
// four destinations through a demux select. The destination is picked in
// round-robin order among the enabled ones. If the chosen destination stalls
// for TIMEOUT cycles, or is disabled while the word is pending, the word is
// retargeted to the next enabled destination. If every destination is disabled
// while a word is pending, the word is dropped.
//
// Ports:
//   clk           system clock (rising edge)
//   rst_n         asynchronous active-low reset
//   in_valid      source word available
//   in_data       source word [DW-1:0]
//   in_ready      controller accepts a word this cycle
//   dest_en       per-destination enable mask [3:0]
//   dest_ready    per-destination accept strobe [3:0]
//   sel           index of the current destination [1:0]
//   out_valid     one-hot valid, only bit sel can be set [3:0]
//   out_data      held word, common to all destinations [DW-1:0]
//   busy          a word is being held
//   retarget_cnt  saturating count of retargets [7:0]
// -----------------------------------------------------------------------------
module demux_dispatch_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [3:0]    dest_en,
  input  logic [3:0]    dest_ready,
  output logic [1:0]    sel,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic [7:0]    retarget_cnt
);

  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [DW-1:0] r_hold, w_hold_nxt;
  logic [3:0]    r_stall, w_stall_nxt;
  logic [7:0]    r_rt_cnt, w_rt_cnt_nxt;

  logic [2:0]    w_acc_pick;
  logic [2:0]    w_rt_pick;
  logic [3:0]    w_stall_inc;
  logic          w_timeout;

  // Round-robin search: scans base+1, base+2, base+3 and, when incl_base is
  // set, finally base itself. Returns {found, index}. The loop runs from the
  // lowest priority candidate upward so the last hit wins.
  function automatic logic [2:0] f_pick(input logic [3:0] en,
                                        input logic [1:0] base,
                                        input logic       incl_base);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, base};
    if (incl_base && en[base]) res = {1'b1, base};
    for (int k = 3; k >= 1; k--) begin
      idx = base + 2'(k);
      if (en[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_acc_pick  = f_pick(dest_en, r_ptr, 1'b1);
  assign w_rt_pick   = f_pick(dest_en, r_sel, 1'b0);
  assign w_stall_inc = r_stall + 4'd1;
  // The stall count is compared one step ahead so the select moves exactly
  // after TIMEOUT stalled HOLD cycles.
  assign w_timeout   = (w_stall_inc == LP_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= 2'b00;
      r_ptr    <= 2'b11;
      r_hold   <= '0;
      r_stall  <= 4'd0;
      r_rt_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hold   <= w_hold_nxt;
      r_stall  <= w_stall_nxt;
      r_rt_cnt <= w_rt_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_ptr_nxt    = r_ptr;
    w_hold_nxt   = r_hold;
    w_stall_nxt  = r_stall;
    w_rt_cnt_nxt = r_rt_cnt;
    case (r_state)
      ST_IDLE: begin
        // w_acc_pick[2] is set exactly when any destination is enabled.
        if (in_valid && w_acc_pick[2]) begin
          w_hold_nxt  = in_data;
          w_sel_nxt   = w_acc_pick[1:0];
          w_stall_nxt = 4'd0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (dest_ready[r_sel]) begin
          // Completion wins over a coincident timeout.
          w_ptr_nxt   = r_sel;
          w_stall_nxt = 4'd0;
          w_state_nxt = ST_IDLE;
        end else if (dest_en == 4'b0000) begin
          // Nobody can take the word: drop it, leave ptr and counter alone.
          w_stall_nxt = 4'd0;
          w_state_nxt = ST_IDLE;
        end else if (!dest_en[r_sel] || w_timeout) begin
          // With no other destination enabled the select stays put, but the
          // retarget is still counted.
          if (w_rt_pick[2]) w_sel_nxt = w_rt_pick[1:0];
          w_stall_nxt  = 4'd0;
          w_rt_cnt_nxt = f_sat_inc(r_rt_cnt);
        end else begin
          w_stall_nxt = w_stall_inc;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready     = (r_state == ST_IDLE) && w_acc_pick[2];
  assign busy         = (r_state == ST_HOLD);
  assign out_valid    = (r_state == ST_HOLD) ? (4'b0001 << r_sel) : 4'b0000;
  assign out_data     = r_hold;
  assign sel          = r_sel;
  assign retarget_cnt = r_rt_cnt;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
module tb_demux_dispatch_ctrl;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [3:0]    dest_en;
  logic [3:0]    dest_ready;
  logic [1:0]    sel;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [7:0]    retarget_cnt;

  int checks = 0;
  int errors = 0;

  demux_dispatch_ctrl #(.DW(DW), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .dest_en      (dest_en),
    .dest_ready   (dest_ready),
    .sel          (sel),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .retarget_cnt (retarget_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_sel5 [5];
  logic [1:0] exp_sel4 [4];

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    dest_en    = 4'b0000;
    dest_ready = 4'b0000;
    exp_sel5   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_sel4   = '{2'd0, 2'd2, 2'd0, 2'd2};

    // ---------------- reset state ----------------
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_retarget", 32'(retarget_cnt), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_in_ready_no_en", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- all enabled, always ready: 0,1,2,3,0 ----------------
    dest_en    = 4'b1111;
    dest_ready = 4'b1111;
    in_valid   = 1'b1;
    in_data    = 8'hA1;
    #1;
    chk("rr_in_ready_idle", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_busy_%0d", i), 32'(busy), 32'h1);
      chk($sformatf("rr_sel_%0d", i), 32'(sel), 32'(exp_sel5[i]));
      chk($sformatf("rr_valid_%0d", i), 32'(out_valid), 32'(4'b0001 << exp_sel5[i]));
      chk($sformatf("rr_data_%0d", i), 32'(out_data), 32'(8'hA1 + i));
      chk($sformatf("rr_in_ready_hold_%0d", i), 32'(in_ready), 32'h0);
      in_data = 8'(8'hA2 + i);
      tick();
      chk($sformatf("rr_idle_valid_%0d", i), 32'(out_valid), 32'h0);
      chk($sformatf("rr_idle_busy_%0d", i), 32'(busy), 32'h0);
      if (i == 4) in_valid = 1'b0;
    end

    // ---------------- dest_en=0101: 0,2,0,2 ----------------
    do_reset();
    dest_en    = 4'b0101;
    dest_ready = 4'b1111;
    in_valid   = 1'b1;
    in_data    = 8'hB1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("en5_sel_%0d", i), 32'(sel), 32'(exp_sel4[i]));
      chk($sformatf("en5_valid_%0d", i), 32'(out_valid), 32'(4'b0001 << exp_sel4[i]));
      in_data = 8'(8'hB2 + i);
      tick();
      chk($sformatf("en5_idle_%0d", i), 32'(busy), 32'h0);
      if (i == 3) in_valid = 1'b0;
    end

    // ---------------- timeout retarget 0 -> 1 ----------------
    do_reset();
    dest_en    = 4'b1111;
    dest_ready = 4'b0000;
    in_valid   = 1'b1;
    in_data    = 8'h5A;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("to_valid_c%0d", c), 32'(out_valid), 32'h1);
      chk($sformatf("to_rtcnt_c%0d", c), 32'(retarget_cnt), 32'h0);
      tick();
    end
    chk("to_sel_after", 32'(sel), 32'h1);
    chk("to_valid_after", 32'(out_valid), 32'h2);
    chk("to_rtcnt_after", 32'(retarget_cnt), 32'h1);
    chk("to_data_dest1", 32'(out_data), 32'h5A);
    dest_ready = 4'b0010;
    tick();
    chk("to_done_busy", 32'(busy), 32'h0);
    chk("to_done_valid", 32'(out_valid), 32'h0);
    chk("to_done_data", 32'(out_data), 32'h5A);
    dest_ready = 4'b0000;

    // ---------------- ready exactly on timeout cycle (ptr=1 -> sel 2) ----------------
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid   = 1'b0;
    dest_ready = 4'b1011;   // non-selected ready bits must be ignored
    chk("tc_sel", 32'(sel), 32'h2);
    for (int c = 0; c < 14; c++) tick();
    chk("tc_still_hold", 32'(busy), 32'h1);
    chk("tc_still_sel", 32'(sel), 32'h2);
    dest_ready = 4'b0100;
    tick();
    chk("tc_done_busy", 32'(busy), 32'h0);
    chk("tc_rtcnt_same", 32'(retarget_cnt), 32'h1);
    chk("tc_sel_same", 32'(sel), 32'h2);
    dest_ready = 4'b0000;

    // ---------------- drop on dest_en=0 (ptr=2) ----------------
    dest_en  = 4'b0100;
    in_valid = 1'b1;
    in_data  = 8'hD4;
    tick();
    in_valid = 1'b0;
    chk("drop_sel", 32'(sel), 32'h2);
    dest_en = 4'b0000;
    tick();
    chk("drop_busy", 32'(busy), 32'h0);
    chk("drop_in_ready", 32'(in_ready), 32'h0);
    chk("drop_rtcnt", 32'(retarget_cnt), 32'h1);
    chk("drop_valid", 32'(out_valid), 32'h0);
    dest_en  = 4'b1000;
    in_valid = 1'b1;
    in_data  = 8'hE5;
    #1;
    chk("drop_in_ready_restored", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("drop_next_sel", 32'(sel), 32'h3);
    chk("drop_next_data", 32'(out_data), 32'hE5);
    dest_ready = 4'b1000;
    tick();
    chk("drop_next_done", 32'(busy), 32'h0);
    dest_ready = 4'b0000;

    // ---------------- lone destination timeout, then disabled sel ----------------
    dest_en  = 4'b0001;
    in_valid = 1'b1;
    in_data  = 8'hF6;
    tick();
    in_valid = 1'b0;
    chk("lone_sel", 32'(sel), 32'h0);
    for (int c = 0; c < 15; c++) tick();
    chk("lone_sel_kept", 32'(sel), 32'h0);
    chk("lone_busy", 32'(busy), 32'h1);
    chk("lone_rtcnt", 32'(retarget_cnt), 32'h2);
    dest_en = 4'b0110;
    tick();
    chk("dis_sel", 32'(sel), 32'h1);
    chk("dis_rtcnt", 32'(retarget_cnt), 32'h3);
    chk("dis_valid", 32'(out_valid), 32'h2);
    dest_ready = 4'b0010;
    tick();
    chk("dis_done", 32'(busy), 32'h0);
    dest_ready = 4'b0000;

    // ---------------- async reset in HOLD (ptr=1 -> sel 2) ----------------
    dest_en  = 4'b1111;
    in_valid = 1'b1;
    in_data  = 8'h17;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_sel", 32'(sel), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_busy", 32'(busy), 32'h0);
    chk("ar_sel", 32'(sel), 32'h0);
    chk("ar_rtcnt", 32'(retarget_cnt), 32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    dest_ready = 4'b1111;
    in_valid   = 1'b1;
    in_data    = 8'h77;
    tick();
    in_valid = 1'b0;
    chk("ar_first_sel", 32'(sel), 32'h0);
    chk("ar_first_valid", 32'(out_valid), 32'h1);
    chk("ar_first_data", 32'(out_data), 32'h77);
    tick();
    chk("ar_first_done", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
